// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package display_pkg;

    localparam logic [6:0] BLANK_CODE = 7'h7F;

    typedef enum logic [1:0] {
        SRC_BLANK = 2'd0,
        SRC_TEL   = 2'd1,
        SRC_ALERT = 2'd2
    } src_e;

    // Decimal nibbles pass through as digit codes; anything else is shown dark.
    function automatic logic [6:0] nib2code(input logic [3:0] nib);
        return (nib <= 4'd9) ? {3'b000, nib} : BLANK_CODE;
    endfunction

endpackage

// File: rtl/display_scheduler_refresh_tick_gen.sv
// Free-running modulo-PERIOD counter; tick is high for the single wrap cycle.
module refresh_tick_gen #(
    parameter int PERIOD = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the 8-digit display between telemetry (tick-committed) and alerts (preempting).
// Build option LEAD_ZERO_BLANK_EN: blank leading zeros of telemetry frames.
module display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES    = 100_000,
    parameter int ALERT_HOLD_CYCLES = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tel_valid,
    input  logic [31:0] tel_data,
    output logic        tel_ready,
    input  logic        alr_valid,
    input  logic [31:0] alr_data,
    output logic        alr_ready,
    input  logic        alr_ack,
    output logic [6:0]  dig0,
    output logic [6:0]  dig1,
    output logic [6:0]  dig2,
    output logic [6:0]  dig3,
    output logic [6:0]  dig4,
    output logic [6:0]  dig5,
    output logic [6:0]  dig6,
    output logic [6:0]  dig7,
    output logic [1:0]  src_sel,
    output logic        alert_active
);

    localparam int HW = (ALERT_HOLD_CYCLES > 1) ? $clog2(ALERT_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ALERT_HOLD_CYCLES - 1);

    logic          tick;
    logic          rdy_q;
    logic          shadow_full_q;
    logic          tel_seen_q;
    logic [31:0]   shadow_q;
    logic [31:0]   tel_buf_q;
    logic [31:0]   alr_buf_q;
    logic [HW-1:0] hold_q;
    src_e          state_q;
    logic [6:0]    tel_code [8];
    logic [6:0]    dig_p1 [8];
    logic          tel_xfer;
    logic          alr_xfer;
    logic          commit;
    logic          alr_exit;

    refresh_tick_gen #(.PERIOD(REFRESH_CYCLES)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign tel_ready = rdy_q & ~shadow_full_q;
    assign alr_ready = rdy_q;
    assign tel_xfer  = tel_valid & tel_ready;
    assign alr_xfer  = alr_valid & rdy_q;
    // A frame accepted in the tick cycle has an empty shadow here, so it waits a full period.
    assign commit    = tick & shadow_full_q;
    assign alr_exit  = (hold_q == '0) | alr_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q         <= 1'b0;
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
            tel_buf_q     <= '0;
            tel_seen_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (commit) begin
                tel_buf_q     <= shadow_q;
                tel_seen_q    <= 1'b1;
                shadow_full_q <= 1'b0;
            end else if (tel_xfer) begin
                shadow_q      <= tel_data;
                shadow_full_q <= 1'b1;
            end
        end
    end

    // An alert transfer overrides everything, including a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SRC_BLANK;
            hold_q    <= '0;
            alr_buf_q <= '0;
        end else if (alr_xfer) begin
            alr_buf_q <= alr_data;
            hold_q    <= HOLD_LOAD;
            state_q   <= SRC_ALERT;
        end else begin
            case (state_q)
                SRC_BLANK: if (commit) state_q <= SRC_TEL;
                SRC_TEL:   state_q <= SRC_TEL;
                SRC_ALERT: begin
                    if (alr_exit)
                        state_q <= (tel_seen_q | commit) ? SRC_TEL : SRC_BLANK;
                    else
                        hold_q <= hold_q - HW'(1);
                end
                default:   state_q <= SRC_BLANK;
            endcase
        end
    end

    always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        for (int i = 7; i >= 0; i--) begin
            tel_code[i] = nib2code(tel_buf_q[4*i +: 4]);
`ifdef LEAD_ZERO_BLANK_EN
            if (i > 0 && lead && tel_buf_q[4*i +: 4] == 4'd0)
                tel_code[i] = BLANK_CODE;
            else
                lead = 1'b0;
`endif
        end
    end

    // Output stage: digits follow state/buffers with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) dig_p1[i] <= BLANK_CODE;
        end else begin
            for (int i = 0; i < 8; i++) begin
                case (state_q)
                    SRC_TEL:   dig_p1[i] <= tel_code[i];
                    SRC_ALERT: dig_p1[i] <= nib2code(alr_buf_q[4*i +: 4]);
                    default:   dig_p1[i] <= BLANK_CODE;
                endcase
            end
        end
    end

    assign dig0         = dig_p1[0];
    assign dig1         = dig_p1[1];
    assign dig2         = dig_p1[2];
    assign dig3         = dig_p1[3];
    assign dig4         = dig_p1[4];
    assign dig5         = dig_p1[5];
    assign dig6         = dig_p1[6];
    assign dig7         = dig_p1[7];
    assign src_sel      = state_q;
    assign alert_active = (state_q == SRC_ALERT);

endmodule
